// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state enum, bubble instruction and default datapath width
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int DEFAULT_XLEN = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory address, IF/ID register and stall/flush counters
module fetch_stage #(
  parameter int              XLEN       = cpu_pkg::DEFAULT_XLEN,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  import cpu_pkg::*;
  typedef struct packed {
    logic [XLEN-1:0] pc_o;
    logic [31:0]     instr_o;
    logic            valid_o;
  } ifid_t;
  localparam ifid_t BUBBLE = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};
  fetch_state_e state, state_n;
  ifid_t ifid, ifid_n;
  logic [XLEN-1:0] pc, pc_n, tgt;
  logic run, pc_ok, tgt_ok, do_flush, do_stall, do_fetch, do_halt;
  always_comb begin
    tgt = branch_target_i & ~XLEN'(3);
    pc_ok = (pc >> 2) < XLEN'(IMEM_DEPTH);
    tgt_ok = (tgt >> 2) < XLEN'(IMEM_DEPTH);
    run = state == RUN && start_i;
    do_flush = (run && flush_i) || (state == HALT && flush_i && tgt_ok);
    do_stall = run && !flush_i && stall_i;
    do_fetch = run && !flush_i && !stall_i && pc_ok;
    do_halt = run && !flush_i && !stall_i && !pc_ok;
    state_n = state == IDLE ? (start_i ? RUN : IDLE) : do_halt ? HALT : do_flush ? RUN : state;
    pc_n = do_flush ? tgt : do_fetch ? pc + XLEN'(4) : pc;
    ifid_n = (do_flush || do_halt) ? BUBBLE : do_fetch ? ifid_t'({pc, imem_data_i, 1'b1}) : ifid;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc <= RESET_PC;
      ifid <= BUBBLE;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ifid <= ifid_n;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk_i), .clr(rst_i), .inc(do_stall), .cnt(stall_cnt_o));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk_i), .clr(rst_i), .inc(do_flush), .cnt(flush_cnt_o));
  assign pc_o = pc;
  assign imem_addr_o = pc;
  assign ifid_pc_o = ifid.pc_o;
  assign ifid_instr_o = ifid.instr_o;
  assign ifid_valid_o = ifid.valid_o;
  assign halted_o = state == HALT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage with 2-bit counters to reach saturation
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_i, start_i, stall_i, flush_i;
  logic [31:0] branch_target_i, imem_addr_o, imem_data_i, pc_o, ifid_pc_o, ifid_instr_o;
  logic ifid_valid_o, halted_o;
  logic [1:0] stall_cnt_o, flush_cnt_o;
  typedef struct {
    logic [31:0] pc, ipc, ins;
    logic v, h;
    logic [1:0] sc, fc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [256];
  fetch_stage #(.XLEN(32), .IMEM_DEPTH(256), .RESET_PC(32'h0), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o), .ifid_valid_o(ifid_valid_o),
    .halted_o(halted_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  always #5 clk = ~clk;
  assign imem_data_i = imem_addr_o[31:10] == 22'd0 ? mem[imem_addr_o[9:2]] : 32'hbad0_0bad;
  function automatic logic [31:0] w(int k);
    return 32'h1000_0000 | 32'(k);
  endfunction
  function automatic exp_t x(logic [31:0] pc, logic [31:0] ipc, logic [31:0] ins, logic v, logic h, logic [1:0] sc, logic [1:0] fc);
    exp_t e;
    e.pc = pc; e.ipc = ipc; e.ins = ins; e.v = v; e.h = h; e.sc = sc; e.fc = fc;
    return e;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("imem_addr_o", imem_addr_o, e.pc);
      chk("ifid_pc_o", ifid_pc_o, e.ipc);
      chk("ifid_instr_o", ifid_instr_o, e.ins);
      chk("ifid_valid_o", 32'(ifid_valid_o), 32'(e.v));
      chk("halted_o", 32'(halted_o), 32'(e.h));
      chk("stall_cnt_o", 32'(stall_cnt_o), 32'(e.sc));
      chk("flush_cnt_o", 32'(flush_cnt_o), 32'(e.fc));
    end
  end
  task automatic step(logic rs, logic st, logic sl, logic fl, logic [31:0] tg, exp_t e);
    rst_i = rs; start_i = st; stall_i = sl; flush_i = fl; branch_target_i = tg;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  initial begin
    exp_t r;
    r = x(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) mem[i] = w(i);
    rst_i = 1; start_i = 0; stall_i = 0; flush_i = 0; branch_target_i = 0;
    step(1, 0, 0, 0, 0, r);
    step(1, 1, 1, 1, 32'h40, r);
    step(0, 0, 0, 0, 0, r);
    step(0, 1, 0, 0, 0, r);
    step(0, 1, 0, 0, 0, x(4, 0, w(0), 1, 0, 0, 0));
    step(0, 1, 0, 0, 0, x(8, 4, w(1), 1, 0, 0, 0));
    step(0, 1, 1, 0, 0, x(8, 4, w(1), 1, 0, 1, 0));
    step(0, 1, 1, 0, 0, x(8, 4, w(1), 1, 0, 2, 0));
    step(0, 1, 0, 0, 0, x(12, 8, w(2), 1, 0, 2, 0));
    step(0, 1, 0, 1, 32'h40, x(32'h40, 0, 0, 0, 0, 2, 1));
    step(0, 1, 0, 0, 0, x(32'h44, 32'h40, w(16), 1, 0, 2, 1));
    step(0, 1, 1, 1, 32'h22, x(32'h20, 0, 0, 0, 0, 2, 2));
    step(0, 1, 0, 0, 0, x(32'h24, 32'h20, w(8), 1, 0, 2, 2));
    step(0, 0, 1, 0, 0, x(32'h24, 32'h20, w(8), 1, 0, 2, 2));
    step(0, 1, 0, 0, 0, x(32'h28, 32'h24, w(9), 1, 0, 2, 2));
    for (int k = 10; k < 256; k++) step(0, 1, 0, 0, 0, x(32'(4 * (k + 1)), 32'(4 * k), w(k), 1, 0, 2, 2));
    step(0, 1, 0, 0, 0, x(1024, 0, 0, 0, 1, 2, 2));
    step(0, 1, 1, 0, 0, x(1024, 0, 0, 0, 1, 2, 2));
    step(0, 1, 0, 1, 32'h800, x(1024, 0, 0, 0, 1, 2, 2));
    step(0, 1, 0, 1, 32'h3, x(0, 0, 0, 0, 0, 2, 3));
    step(0, 1, 0, 0, 0, x(4, 0, w(0), 1, 0, 2, 3));
    step(0, 1, 1, 0, 0, x(4, 0, w(0), 1, 0, 3, 3));
    step(0, 1, 1, 0, 0, x(4, 0, w(0), 1, 0, 3, 3));
    step(0, 1, 0, 1, 32'h10, x(32'h10, 0, 0, 0, 0, 3, 3));
    step(0, 1, 1, 0, 0, x(32'h10, 0, 0, 0, 0, 3, 3));
    step(1, 1, 1, 1, 32'h80, r);
    step(0, 0, 0, 0, 0, r);
    step(0, 0, 1, 1, 32'h80, r);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the five-stage pipelined CPU: owns the program counter, drives the instruction-memory read address and registers the fetched word into the IF/ID pipeline register. It sits directly upstream of the decode stage, consuming the stall/flush/branch-target feedback from hazard detection and branch resolution in ID. It also keeps saturating stall and flush event counters for the bench's per-cycle trace.

## Interface

- XLEN, 32, datapath/address width
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words
- RESET_PC, 0, byte address loaded into PC on reset
- CNT_W, 32, width of event counters

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  CPU run enable; fetch advances only while high
- stall_i  in  1  load-use stall from hazard detection: hold PC and IF/ID
- flush_i  in  1  branch taken in ID: redirect PC, bubble IF/ID
- branch_target_i  in  XLEN  redirect byte address, valid with flush_i
- imem_addr_o  out  XLEN  instruction memory byte address (= pc_o)
- imem_data_i  in  32  instruction word, combinational read of imem_addr_o
- pc_o  out  XLEN  current fetch PC
- ifid_pc_o  out  XLEN  PC of instruction in IF/ID
- ifid_instr_o  out  32  instruction in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real instruction (not bubble)
- halted_o  out  1  fetch ran past end of instruction memory
- stall_cnt_o  out  CNT_W  cycles with effective stall
- flush_cnt_o  out  CNT_W  cycles with effective flush

## Operation

- States: IDLE, RUN, HALT.
- IDLE: PC holds RESET_PC, IF/ID holds bubble. start_i=1 -> RUN (first fetch occurs in the RUN cycle, not the transition cycle).
- RUN, priority per cycle: flush_i > stall_i > normal.
  - flush: PC <= branch_target_i; IF/ID <= bubble (instr 0, valid 0, pc 0); flush_cnt++.
  - stall (flush low): PC and IF/ID unchanged; stall_cnt++.
  - normal: IF/ID <= {pc_o, imem_data_i, valid 1}; PC <= PC+4 (mod 2^XLEN).
- Fetch address out of range (pc_o >> 2 >= IMEM_DEPTH): imem_data_i ignored, bubble loaded, PC held, state -> HALT.
- HALT: halted_o=1, PC holds, IF/ID bubbles. flush_i with in-range target -> RUN with PC <= target, flush_cnt++; out-of-range target stays HALT. stall_i ignored.
- start_i low in RUN: freeze exactly as stall, but counters do not increment; state stays RUN.
- Counters saturate at all-ones; count only in RUN (flush also in HALT as above).
- Bubble is instruction 32'b0, matching the zero-initialised instruction memory.
- Misaligned branch_target_i: low two bits forced to 0.

## Timing

- Reset (rst_i=1 on an edge, any state, mid-stall or mid-flush): state IDLE, pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=0, ifid_valid_o=0, halted_o=0, both counters 0. rst_i wins over all other inputs.
- imem_addr_o = pc_o combinationally; zero-cycle memory read.
- Fetch-to-IF/ID latency: 1 cycle. Redirect: target appears on pc_o the cycle after flush_i, its instruction in IF/ID one cycle later.
- stall_i/flush_i/branch_target_i sampled only at the rising edge; no combinational path from them to any output.
- Simultaneous stall_i and flush_i: flush only, counted as flush, not stall.

## Structure

- Shared package cpu_pkg: fetch state enum, NOP_INSTR constant (32'b0), XLEN default.
- Sub-module sat_counter (width parameter, synchronous clear, increment enable, saturation), instantiated twice.
- PC register and IF/ID register in this module; name IF/ID fields pc_o/instr_o internally so the bench's pipeline-register initialisation style applies.

## Test plan

- Reset then start_i=1, memory words 0..3 nonzero -> pc_o 0,4,8,12 on successive cycles; ifid_instr_o = word k one cycle after pc_o=4k; ifid_valid_o=1.
- stall_i high 2 cycles at pc_o=8 -> pc_o stays 8, IF/ID unchanged, stall_cnt_o=2, then resumes at 12.
- flush_i with target 0x40 while pc_o=12 -> next pc_o=0x40, IF/ID bubble (valid 0), flush_cnt_o=1; word 16 in IF/ID next cycle.
- stall_i and flush_i together, target 0x20 -> pc_o=0x20, flush_cnt +1, stall_cnt unchanged.
- Run to pc_o=1024 with IMEM_DEPTH=256 -> halted_o=1, PC holds 1024, IF/ID bubbles; flush to 0x0 -> RUN, pc_o=0.
- rst_i asserted mid-stall with counters nonzero -> all outputs at reset values next cycle; start_i low keeps IDLE.
